// File: rtl/p2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p2s_pkg
// Description : Shared types for the p2s parallel-to-serial converter.
//               p2s_state_t - converter state: RX waits for a parallel word,
//               TX shifts the word out one bit per accepted serial beat.
// Revision    : 1.0 - initial release
// ============================================================================
package p2s_pkg;

  typedef enum logic {
    RX = 1'b0,
    TX = 1'b1
  } p2s_state_t;

endpackage : p2s_pkg
`default_nettype wire

// File: rtl/p2s.sv
`default_nettype none
// ============================================================================
// Module      : p2s
// Description : AXI-Stream style parallel-to-serial converter. Accepts one
//               N-bit word on a valid/ready parallel input and emits it LSB
//               first, one bit per beat, on a 1-bit valid/ready output.
//               One word every N+1 cycles at full serial throughput.
// Ports       : clk        - system clock, rising edge
//               rstn       - asynchronous reset, ACTIVE HIGH (name kept for
//                            codebase consistency)
//               par_data   - parallel word in (N bits)
//               par_valid  - par_data valid
//               par_ready  - converter can take a word (idle)
//               ser_data   - current serial bit
//               ser_valid  - ser_data valid
//               ser_ready  - downstream takes ser_data this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module p2s
  import p2s_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] par_data,
  input  logic         par_valid,
  output logic         par_ready,
  output logic         ser_data,
  output logic         ser_valid,
  input  logic         ser_ready
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  p2s_state_t    state, state_nxt;
  logic [N-1:0]  shreg, shreg_nxt;
  logic [CW-1:0] cnt,   cnt_nxt;

  // Outputs depend on registers only: no input-to-output combinational path.
  assign par_ready = (state == RX);
  assign ser_valid = (state == TX);
  assign ser_data  = shreg[0];

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state <= RX;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      RX: begin
        // ser_ready is irrelevant here; only a parallel handshake moves us on.
        if (par_valid) begin
          shreg_nxt = par_data;
          cnt_nxt   = '0;
          state_nxt = TX;
        end
      end
      TX: begin
        // Without ser_ready everything holds, keeping ser_data stable.
        if (ser_ready) begin
          // Zero fill leaves shreg at 0 after the last beat, so ser_data
          // idles low in RX.
          shreg_nxt = shreg >> 1;
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = RX;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = RX;
      end
    endcase
  end

endmodule : p2s
`default_nettype wire

// File: tb/tb_p2s.sv
`default_nettype none
// ============================================================================
// Module      : tb_p2s
// Description : Self-checking bench for p2s (N = 8). A bit-queue scoreboard
//               is filled on every parallel handshake and drained on every
//               serial beat; each cycle the DUT outputs are compared with
//               what the queue implies. A table of words with expected bit
//               streams and optional stalls drives the main checks, followed
//               by hand-written reset, idle, overrun and mid-word reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p2s;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] par_data = '0;
  logic         par_valid = 1'b0;
  logic         par_ready;
  logic         ser_data;
  logic         ser_valid;
  logic         ser_ready = 1'b0;

  p2s #(.N(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .par_data  (par_data),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  logic sbq[$];
  logic acc_seen;
  logic beat_seen;
  logic beat_bit;

  typedef struct {
    logic [N-1:0] word;
    logic [N-1:0] exp_bits;  // bit i = i-th serial bit expected
    int           st_at;     // beat index at which to stall (-1 = none)
    int           st_len;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a falling edge with inputs already driven. Checks outputs
  // against the scoreboard, models the coming rising edge, then advances.
  task automatic tick();
    logic empty;
    empty = (sbq.size() == 0);
    chk("par_ready", {31'd0, par_ready}, {31'd0, empty});
    chk("ser_valid", {31'd0, ser_valid}, {31'd0, !empty});
    chk("ser_data",  {31'd0, ser_data},  {31'd0, empty ? 1'b0 : sbq[0]});
    acc_seen  = 1'b0;
    beat_seen = 1'b0;
    beat_bit  = ser_data;
    if (empty && par_valid) begin
      acc_seen = 1'b1;
      for (int i = 0; i < N; i++) sbq.push_back(par_data[i]);
    end else if (!empty && ser_ready) begin
      beat_seen = 1'b1;
      void'(sbq.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs until n serial beats are seen (bounded), stalling ser_ready for
  // st_len cycles once st_at beats have completed. par_valid drops after
  // a word is accepted.
  task automatic collect(input int n, input logic [N-1:0] exp, input int st_at,
                         input int st_len, output logic [N-1:0] cap, output int got);
    int stalled;
    stalled = 0;
    cap = '0;
    got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      if (got == st_at && stalled < st_len) begin
        ser_ready = 1'b0;
        stalled++;
        chk("stall_valid", {31'd0, ser_valid}, 32'd1);
        chk("stall_data",  {31'd0, ser_data},  {31'd0, exp[got]});
      end else begin
        ser_ready = 1'b1;
      end
      tick();
      if (acc_seen) par_valid = 1'b0;
      if (beat_seen) begin
        cap[got] = beat_bit;
        got++;
      end
    end
    ser_ready = 1'b1;
    chk("beat_count", got, n);
  endtask

  task automatic send(input logic [N-1:0] w);
    par_data  = w;
    par_valid = 1'b1;
    ser_ready = 1'b1;
    tick();
    chk("accepted", {31'd0, acc_seen}, 32'd1);
    par_valid = 1'b0;
  endtask

  initial begin
    logic [N-1:0] cap;
    int           got;

    vecs[0] = '{word: 8'h3E, exp_bits: 8'b0011_1110, st_at: -1, st_len: 0};
    vecs[1] = '{word: 8'h34, exp_bits: 8'b0011_0100, st_at: 2,  st_len: 4};
    vecs[2] = '{word: 8'hA5, exp_bits: 8'b1010_0101, st_at: 7,  st_len: 3};
    vecs[3] = '{word: 8'h80, exp_bits: 8'b1000_0000, st_at: 0,  st_len: 2};

    // Reset asserted mid-cycle, outputs checked immediately and after release.
    @(negedge clk);
    #2 rstn = 1'b1;
    #1;
    chk("rst_par_ready", {31'd0, par_ready}, 32'd1);
    chk("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("rst_ser_data",  {31'd0, ser_data},  32'd0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    tick();

    // Idle: data present but not valid.
    par_data  = 8'd7;
    par_valid = 1'b0;
    ser_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_acc", {31'd0, acc_seen}, 32'd0);
    end

    // Table-driven words, some with backpressure.
    foreach (vecs[v]) begin
      send(vecs[v].word);
      collect(N, vecs[v].exp_bits, vecs[v].st_at, vecs[v].st_len, cap, got);
      chk($sformatf("stream_%0d", v), {24'd0, cap}, {24'd0, vecs[v].exp_bits});
      tick();
      chk($sformatf("ready_after_%0d", v), {31'd0, par_ready}, 32'd1);
    end

    // Overrun: 0xFF held valid while 0x3E is still shifting out.
    send(8'h3E);
    par_data  = 8'hFF;
    par_valid = 1'b1;
    collect(N, 8'h3E, -1, 0, cap, got);
    chk("overrun_first", {24'd0, cap}, 32'h3E);
    chk("overrun_pending_valid", {31'd0, par_valid}, 32'd1);
    collect(N, 8'hFF, -1, 0, cap, got);
    chk("overrun_second", {24'd0, cap}, 32'hFF);
    tick();

    // Reset after the 3rd beat aborts the word.
    send(8'h96);
    collect(3, 8'h96, -1, 0, cap, got);
    chk("pre_rst_bits", {29'd0, cap[2:0]}, 32'd6);
    #2 rstn = 1'b1;
    #1;
    chk("midrst_ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("midrst_par_ready", {31'd0, par_ready}, 32'd1);
    chk("midrst_ser_data",  {31'd0, ser_data},  32'd0);
    sbq.delete();
    @(negedge clk);
    rstn = 1'b0;
    tick();
    send(8'h01);
    collect(N, 8'h01, -1, 0, cap, got);
    chk("post_rst_stream", {24'd0, cap}, 32'h01);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_p2s
`default_nettype wire
